// File: rtl/baseline_dot8_pkg.sv
// Shared constants for the baseline 8-lane signed dot-product datapath.
// Operand width defaults, lane split and the partial-sum width rule live here.
package baseline_dot8_pkg;

  localparam int IN_SIZE_0_DEF = 4;
  localparam int IN_SIZE_1_DEF = 8;
  localparam int LANES         = 8;
  localparam int TERMS         = 4;
  localparam int HALVES        = LANES / TERMS;

  // +2 bits absorb a 4-term sum; +2 more keep the sum of both halves exact.
  function automatic int out_size(input int a_w, input int b_w);
    return a_w + b_w + 4;
  endfunction

endpackage

// File: rtl/baseline_dot8_if.sv
// Operand/result bundle for baseline_dot8: eight A/B element pairs in,
// two signed partial sums out.
interface baseline_dot8_if
  import baseline_dot8_pkg::*;
#(
  parameter int IN_SIZE_0 = IN_SIZE_0_DEF,
  parameter int IN_SIZE_1 = IN_SIZE_1_DEF
) ();

  localparam int OUT_SIZE = out_size(IN_SIZE_0, IN_SIZE_1);

  logic signed [IN_SIZE_0-1:0] in_0_i [0:LANES-1];
  logic signed [IN_SIZE_1-1:0] in_1_i [0:LANES-1];
  logic signed [OUT_SIZE-1:0]  out_o  [0:HALVES-1];

  modport master (
    output in_0_i,
    output in_1_i,
    input  out_o
  );

  modport slave (
    input  in_0_i,
    input  in_1_i,
    output out_o
  );

endinterface

// File: rtl/baseline_dot4_lane.sv
// One half of the dot product: four signed multipliers, a product register,
// a 4-term adder tree and the partial-sum register.
module baseline_dot4_lane
  import baseline_dot8_pkg::*;
#(
  parameter int A_W = IN_SIZE_0_DEF,
  parameter int B_W = IN_SIZE_1_DEF,
  localparam int PROD_W = A_W + B_W,
  localparam int OUT_W  = out_size(A_W, B_W)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic signed [A_W-1:0]   a_i [0:TERMS-1],
  input  logic signed [B_W-1:0]   b_i [0:TERMS-1],
  output logic signed [OUT_W-1:0] sum_o
);

  logic signed [PROD_W-1:0] prod_p1_d [0:TERMS-1];
  logic signed [PROD_W-1:0] prod_p1_q [0:TERMS-1];
  logic signed [OUT_W-1:0]  sum_p2_d;
  logic signed [OUT_W-1:0]  sum_p2_q;

  function automatic logic signed [OUT_W-1:0] sext(input logic signed [PROD_W-1:0] p);
    return OUT_W'(p);
  endfunction

  // Stage 1: full-precision products; -min * -min fits because PROD_W = A_W + B_W.
  always_comb begin
    for (int i = 0; i < TERMS; i++) begin
      prod_p1_d[i] = a_i[i] * b_i[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < TERMS; i++) prod_p1_q[i] <= '0;
    end else begin
      for (int i = 0; i < TERMS; i++) prod_p1_q[i] <= prod_p1_d[i];
    end
  end

  // Stage 2: balanced adder tree on sign-extended products.
  always_comb begin
    sum_p2_d = (sext(prod_p1_q[0]) + sext(prod_p1_q[1]))
             + (sext(prod_p1_q[2]) + sext(prod_p1_q[3]));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sum_p2_q <= '0;
    else       sum_p2_q <= sum_p2_d;
  end

  assign sum_o = sum_p2_q;

endmodule

// File: rtl/baseline_dot8.sv
// Baseline pipelined 8-element signed dot product; two registered partial
// sums whose total is the dot product, 2-cycle latency, one vector per cycle.
module baseline_dot8
  import baseline_dot8_pkg::*;
#(
  parameter int IN_SIZE_0 = IN_SIZE_0_DEF,
  parameter int IN_SIZE_1 = IN_SIZE_1_DEF
) (
  input  logic           clk_i,
  input  logic           rst_i,
  baseline_dot8_if.slave dot_if
);

  localparam int OUT_SIZE = out_size(IN_SIZE_0, IN_SIZE_1);

  logic signed [IN_SIZE_0-1:0] a_lo [0:TERMS-1];
  logic signed [IN_SIZE_0-1:0] a_hi [0:TERMS-1];
  logic signed [IN_SIZE_1-1:0] b_lo [0:TERMS-1];
  logic signed [IN_SIZE_1-1:0] b_hi [0:TERMS-1];
  logic signed [OUT_SIZE-1:0]  sum_lo;
  logic signed [OUT_SIZE-1:0]  sum_hi;

  for (genvar g = 0; g < TERMS; g++) begin : g_split
    assign a_lo[g] = dot_if.in_0_i[g];
    assign b_lo[g] = dot_if.in_1_i[g];
    assign a_hi[g] = dot_if.in_0_i[g+TERMS];
    assign b_hi[g] = dot_if.in_1_i[g+TERMS];
  end

  baseline_dot4_lane #(
    .A_W (IN_SIZE_0),
    .B_W (IN_SIZE_1)
  ) u_lane_lo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .a_i   (a_lo),
    .b_i   (b_lo),
    .sum_o (sum_lo)
  );

  baseline_dot4_lane #(
    .A_W (IN_SIZE_0),
    .B_W (IN_SIZE_1)
  ) u_lane_hi (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .a_i   (a_hi),
    .b_i   (b_hi),
    .sum_o (sum_hi)
  );

  assign dot_if.out_o[0] = sum_lo;
  assign dot_if.out_o[1] = sum_hi;

endmodule

// File: tb/tb_baseline_dot8.sv
// Directed and random checks of baseline_dot8: reset, extreme operands,
// held and back-to-back vectors, and a mid-stream reset.
module tb_baseline_dot8;

  localparam int N_B2B = 40;
  localparam int R_AT  = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  baseline_dot8_if #(.IN_SIZE_0(4), .IN_SIZE_1(8)) dot_if ();

  baseline_dot8 #(.IN_SIZE_0(4), .IN_SIZE_1(8)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .dot_if (dot_if)
  );

  int va [0:7];
  int vb [0:7];
  int exp_lo [0:N_B2B-1];
  int exp_hi [0:N_B2B-1];

  task automatic check(input string tag, input int obs, input int expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    for (int i = 0; i < 8; i++) begin
      dot_if.in_0_i[i] = 4'(va[i]);
      dot_if.in_1_i[i] = 8'(vb[i]);
    end
  endtask

  task automatic set_all(input int a, input int b);
    for (int i = 0; i < 8; i++) begin
      va[i] = a;
      vb[i] = b;
    end
    apply();
  endtask

  task automatic randomize_vec();
    for (int i = 0; i < 8; i++) begin
      va[i] = int'($urandom_range(0, 15)) - 8;
      vb[i] = int'($urandom_range(0, 255)) - 128;
    end
    apply();
  endtask

  function automatic int golden_half(input int h);
    int s = 0;
    for (int i = 0; i < 4; i++) s += va[4*h+i] * vb[4*h+i];
    return s;
  endfunction

  task automatic check_pair(input string tag, input int lo, input int hi);
    check({tag, "_lo"}, int'(dot_if.out_o[0]), lo);
    check({tag, "_hi"}, int'(dot_if.out_o[1]), hi);
  endtask

  int lo_o, hi_o;

  initial begin
    // Reset held for 5 cycles with arbitrary inputs
    rst = 1'b1;
    randomize_vec();
    for (int c = 0; c < 5; c++) step();
    check_pair("reset", 0, 0);

    rst = 1'b0;
    set_all(0, 0);
    step();
    check_pair("zero_1", 0, 0);
    step();
    check_pair("zero_2", 0, 0);

    set_all(7, 127);
    step(); step();
    check_pair("maxmax", 3556, 3556);
    check("maxmax_sum", int'(dot_if.out_o[0]) + int'(dot_if.out_o[1]), 7112);

    set_all(-8, -128);
    step(); step();
    check_pair("minmin", 4096, 4096);
    check("minmin_sum", int'(dot_if.out_o[0]) + int'(dot_if.out_o[1]), 8192);

    set_all(7, -128);
    step(); step();
    check_pair("pos_neg", -3584, -3584);
    check("pos_neg_sum", int'(dot_if.out_o[0]) + int'(dot_if.out_o[1]), -7168);

    set_all(-8, 127);
    step(); step();
    check_pair("neg_pos", -4064, -4064);
    check("neg_pos_sum", int'(dot_if.out_o[0]) + int'(dot_if.out_o[1]), -8128);

    // Mixed lanes: halves differ so a lane swap shows up
    for (int i = 0; i < 8; i++) begin
      va[i] = (i < 4) ? i - 2 : -i;
      vb[i] = (i < 4) ? 100 - 50 * i : 3 * i - 128;
    end
    apply();
    step(); step();
    // lo: -2*100 + -1*50 + 0*0 + 1*-50 = -300
    // hi: -4*-116 + -5*-113 + -6*-110 + -7*-107 = 464+565+660+749 = 2438
    check_pair("mixed", -300, 2438);

    // Random vectors held for two cycles each
    for (int k = 0; k < 100; k++) begin
      randomize_vec();
      step(); step();
      check("rand_held_sum", int'(dot_if.out_o[0]) + int'(dot_if.out_o[1]),
            golden_half(0) + golden_half(1));
      if (k % 10 == 0) check("rand_held_lo", int'(dot_if.out_o[0]), golden_half(0));
    end

    // Back-to-back traffic with a one-cycle reset at step R_AT
    for (int k = 0; k < N_B2B + 2; k++) begin
      step();
      if (k >= 2) begin
        lo_o = int'(dot_if.out_o[0]);
        hi_o = int'(dot_if.out_o[1]);
        check("b2b_lo", lo_o, exp_lo[k-2]);
        check("b2b_hi", hi_o, exp_hi[k-2]);
        check("b2b_sum", lo_o + hi_o, exp_lo[k-2] + exp_hi[k-2]);
      end
      if (k < N_B2B) begin
        randomize_vec();
        exp_lo[k] = golden_half(0);
        exp_hi[k] = golden_half(1);
        rst = (k == R_AT);
        if (k == R_AT) begin
          exp_lo[k-1] = 0;
          exp_hi[k-1] = 0;
          exp_lo[k]   = 0;
          exp_hi[k]   = 0;
        end
      end else begin
        rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/baseline_dot8.md
Name: baseline_dot8

Overview:
- Pipelined 8-element signed dot-product unit.
- Multiplies eight signed A operands by eight signed B operands element-wise and reduces the products into two partial sums (lower half, upper half).
- Downstream logic adds the two outputs to form the full dot product.
- Serves as the reference (baseline) arithmetic datapath against which optimised AI-core MAC variants are compared for area, power and timing.

Parameters:
- IN_SIZE_0, default 4, width of each signed A element (in_0_i).
- IN_SIZE_1, default 8, width of each signed B element (in_1_i).
- OUT_SIZE (localparam), fixed at IN_SIZE_0+IN_SIZE_1+4, width of each partial-sum output.

Ports:
- clk_i  input  1  single clock; all state updates on its rising edge.
- rst_i  input  1  synchronous, active-high reset.
- in_0_i  input  [IN_SIZE_0-1:0] x8, unpacked array [0:7]  signed A elements.
- in_1_i  input  [IN_SIZE_1-1:0] x8, unpacked array [0:7]  signed B elements.
- out_o  output  [OUT_SIZE-1:0] x2, unpacked array [0:1]  signed partial sums; out_o[0]+out_o[1] equals the dot product.

Behaviour:
- Stage 1, registered: p[i] = signed(in_0_i[i]) * signed(in_1_i[i]), i = 0..7.
  - Each product is IN_SIZE_0+IN_SIZE_1 bits, full precision, two's complement.
- Stage 2, registered:
  - out_o[0] = p[0]+p[1]+p[2]+p[3].
  - out_o[1] = p[4]+p[5]+p[6]+p[7].
  - Products are sign-extended to OUT_SIZE before addition.
- Latency: exactly 2 rising edges from inputs to out_o. Throughput: one new input vector per cycle. No handshake and no valid signal.
- Width rule: a 4-term sum needs +2 bits, so the result cannot overflow. The +4 margin leaves OUT_SIZE wide enough that out_o[0]+out_o[1] also cannot overflow. No saturation or rounding.
- Reset: while rst_i=1 at a rising edge, all product and sum registers clear to 0, so out_o[0]=out_o[1]=0.
  - After rst_i deasserts, the first valid output appears 2 edges later.
  - Reset asserted mid-stream discards all in-flight data on that edge.
- Corner operands:
  - The most-negative × most-negative product (e.g. -8 × -128 = +1024) must be represented exactly as a positive value. No wrap is allowed.
  - Mixed-sign products must sign-extend correctly.
- Inputs are sampled every edge. Holding inputs constant gives constant outputs after 2 cycles.
- No X propagation out of reset: every register has a reset value.

Decomposition:
- Package baseline_dot8_pkg:
  - Holds the default IN_SIZE_0/IN_SIZE_1 values.
  - Holds an OUT_SIZE function/constant.
  - Holds the lane count (8) and terms-per-half (4).
- Sub-module baseline_dot4_lane:
  - 4 signed multipliers, a product register stage, a 4-term adder tree and the sum register.
  - Instantiated twice, for elements 0..3 → out_o[0] and elements 4..7 → out_o[1].

Test Plan (defaults IN_SIZE_0=4, IN_SIZE_1=8, OUT_SIZE=16):
- Reset: hold rst_i=1 for 5 cycles with arbitrary inputs → out_o[0]=out_o[1]=0. Release, apply all-zero inputs → outputs remain 0.
- Max×max: all A=7, all B=127 → after 2 edges out_o[0]=out_o[1]=3556, sum 7112.
- Min×min: all A=-8, all B=-128 → out_o[0]=out_o[1]=4096, sum 8192 (no overflow).
- Mixed signs:
  - all A=7, all B=-128 → each output -3584, sum -7168.
  - all A=-8, all B=127 → each output -4064, sum -8128.
- Random: 100+ random vectors, each held ≥2 cycles, then back-to-back vectors every cycle → out_o[0]+out_o[1] equals the golden Σ A[i]·B[i] exactly 2 cycles after each vector.
- Mid-stream reset: assert rst_i for 1 cycle during back-to-back traffic → outputs 0 on the following cycle. Valid results resume 2 edges after release.
